// File: rtl/mem_stage_responder_if.sv
// ---------------------------------------------------------------------------
// mem_stage_responder_if
//
// Bundles the EX/MEM request lines and the responder's return lines so the
// pipeline side and the data-memory responder connect through one port.
//
// Signals:
//   MemRead_i    load request from the EX/MEM register
//   MemWrite_i   store request from the EX/MEM register
//   Addr_i       byte address (ALU result held in EX/MEM)
//   WriteData_i  store data
//   ReadData_o   data of the most recently completed load
//   stall_o      hold request back to the pipeline
//   done_o       one-cycle completion pulse
//   err_o        one-cycle rejection pulse, coincident with done_o
//
// Modports:
//   master  the pipeline side: drives the request, observes the response
//   slave   the responder side: observes the request, drives the response
// ---------------------------------------------------------------------------
interface mem_stage_responder_if;

  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output MemRead_i,
    output MemWrite_i,
    output Addr_i,
    output WriteData_i,
    input  ReadData_o,
    input  stall_o,
    input  done_o,
    input  err_o
  );

  modport slave (
    input  MemRead_i,
    input  MemWrite_i,
    input  Addr_i,
    input  WriteData_i,
    output ReadData_o,
    output stall_o,
    output done_o,
    output err_o
  );

endinterface

// File: rtl/mem_stage_responder.sv
// ---------------------------------------------------------------------------
// mem_stage_responder
//
// Data-memory responder sitting after the EX/MEM pipeline register. A load or
// store request is served from an internal word-addressed array after a fixed
// number of busy cycles. While the request is in flight the responder stalls
// the pipeline so the EX/MEM register keeps presenting the same request. Load
// data is returned on ReadData_o and held until the next load completes.
//
// Parameters:
//   DEPTH    number of 32-bit words in the array (power of two, >= 2)
//   LATENCY  busy cycles before the access commits (>= 1)
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    asynchronous active-low reset
//   bus      request/response bundle (slave side), see mem_stage_responder_if
// ---------------------------------------------------------------------------
module mem_stage_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mem_stage_responder_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  // Address bits above the word index must be zero for a legal request.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (IDX_W + 2)) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               opWrite_q, opWrite_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               errFlag_q, errFlag_d;
  logic [31:0]        readData_q, readData_d;
  logic               memWe;

  logic [31:0]        mem_q [DEPTH];

  logic               req;
  logic               illegal;
  logic [IDX_W-1:0]   addrIdx;

  // Request decode on the live EX/MEM lines; only meaningful in IDLE.
  assign req     = bus.MemRead_i | bus.MemWrite_i;
  assign illegal = (bus.MemRead_i & bus.MemWrite_i)
                 | (|bus.Addr_i[1:0])
                 | (|(bus.Addr_i & HI_MASK));
  assign addrIdx = bus.Addr_i[IDX_W+1:2];

  // Next-state logic. The request is captured once in IDLE; after that only
  // the latched op/index/data are used, because the pipeline is free to move
  // on during the DONE cycle and the live inputs can no longer be trusted.
  always_comb begin
    state_d    = state_q;
    opWrite_d  = opWrite_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    errFlag_d  = errFlag_q;
    readData_d = readData_q;
    memWe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            errFlag_d = 1'b1;
            state_d   = DONE;
          end else begin
            opWrite_d = bus.MemWrite_i;
            idx_d     = addrIdx;
            wdata_d   = bus.WriteData_i;
            cnt_d     = CNT_INIT;
            state_d   = BUSY;
          end
        end
      end

      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Counter exhausted: the access commits on this edge.
          if (opWrite_q) begin
            memWe = 1'b1;
          end else begin
            readData_d = mem_q[idx_q];
          end
          state_d = DONE;
        end
      end

      DONE: begin
        errFlag_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers. An abort by reset mid-BUSY simply drops
  // the latched request, so no write can leak through.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      opWrite_q  <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      errFlag_q  <= 1'b0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      opWrite_q  <= opWrite_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      errFlag_q  <= errFlag_d;
      readData_q <= readData_d;
    end
  end

  // Storage array. It is cleared by reset so that every word reads back as
  // zero after reset, including after an aborted store.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWe) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // The stall must rise in the same cycle a request first appears, so the
  // IDLE term is taken straight from the live request lines.
  assign bus.stall_o    = ((state_q == IDLE) & req) | (state_q == BUSY);
  assign bus.done_o     = (state_q == DONE);
  assign bus.err_o      = (state_q == DONE) & errFlag_q;
  assign bus.ReadData_o = readData_q;

endmodule
